// File: rtl/rpm_alarm_seq.sv
// rpm_alarm_seq: classifies RPM stage with hysteresis and sequences the over-rev alarm.
// Blinks/beeps in DANGER; after sustained redline enters LIMIT and inhibits accel pulses.
module rpm_alarm_seq #(
    parameter int HOLD_CYCLES  = 200,
    parameter int LIMIT_CYCLES = 1000,
    parameter int BLINK_HALF   = 250,
    parameter int BEEP_ON      = 100,
    parameter int BEEP_OFF     = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] speed_level,
    input  logic [3:0] max_level,
    output logic [1:0] stage,
    output logic       alarm_led,
    output logic       beep,
    output logic       accel_inhibit
);
    typedef enum logic [1:0] {NORMAL, CAUTION, DANGER, LIMIT} state_t;

    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] LIMIT_LAST = 16'(LIMIT_CYCLES - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);
    localparam logic [15:0] ON_LAST    = 16'(BEEP_ON - 1);
    localparam logic [15:0] OFF_LAST   = 16'(BEEP_OFF - 1);

    state_t      st, nxt, raw;
    logic [15:0] hold_cnt, hold_nxt, lim_cnt, lim_nxt, blink_cnt, gate_cnt;
    logic        gate, gate_end, lower;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        raw = (max_level == 4'd0)                      ? NORMAL  :
              (speed_level >= max_level)               ? DANGER  :
              (speed_level >= {1'b0, max_level[3:1]})  ? CAUTION : NORMAL;
    end

    // In LIMIT a DANGER reading is not "lower": only CAUTION/NORMAL start the step-down hold.
    assign lower    = (st == LIMIT) ? (raw != DANGER) : (raw < st);
    assign gate_end = gate_cnt >= (gate ? ON_LAST : OFF_LAST);
    assign stage    = st;

    always_comb begin
        nxt      = st;
        hold_nxt = 16'd0;
        lim_nxt  = 16'd0;
        if (max_level == 4'd0)
            nxt = NORMAL;
        else if (st != LIMIT && raw > st)
            nxt = raw;
        else if (lower) begin
            if (hold_cnt >= HOLD_LAST)
                nxt = raw;
            else
                hold_nxt = sat_inc(hold_cnt);
        end else if (st == DANGER) begin
            if (lim_cnt >= LIMIT_LAST)
                nxt = LIMIT;
            else
                lim_nxt = sat_inc(lim_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= NORMAL;
            hold_cnt <= 16'd0;
            lim_cnt  <= 16'd0;
        end else begin
            st       <= nxt;
            hold_cnt <= hold_nxt;
            lim_cnt  <= lim_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_led     <= 1'b0;
            beep          <= 1'b0;
            accel_inhibit <= 1'b0;
            blink_cnt     <= 16'd0;
            gate_cnt      <= 16'd0;
            gate          <= 1'b0;
        end else if (nxt == DANGER && st != DANGER) begin
            alarm_led     <= 1'b1;
            beep          <= 1'b1;
            accel_inhibit <= 1'b0;
            blink_cnt     <= 16'd0;
            gate_cnt      <= 16'd0;
            gate          <= 1'b1;
        end else if (nxt == DANGER) begin
            alarm_led     <= (blink_cnt >= BLINK_LAST) ? ~alarm_led : alarm_led;
            blink_cnt     <= (blink_cnt >= BLINK_LAST) ? 16'd0 : blink_cnt + 16'd1;
            gate          <= gate ^ gate_end;
            gate_cnt      <= gate_end ? 16'd0 : gate_cnt + 16'd1;
            beep          <= (gate ^ gate_end) & ~beep;
            accel_inhibit <= 1'b0;
        end else begin
            alarm_led     <= nxt == LIMIT;
            beep          <= (nxt == LIMIT) & ~beep;
            accel_inhibit <= nxt == LIMIT;
            blink_cnt     <= 16'd0;
            gate_cnt      <= 16'd0;
            gate          <= 1'b0;
        end
    end
endmodule
